// File: rtl/countones_stream.sv
// countones_stream: popcount of a width_p-bit word, chunk_p bits per cycle,
// with a valid/ready handshake on both the input word and the result.
// Optional feature macro: COUNTONES_STREAM_ACCUM_EN adds clear_i/accum_o,
// a saturating running total of every delivered count.
module countones_stream #(
    parameter int unsigned width_p     = 32,
    parameter int unsigned chunk_p     = 8,
    parameter int unsigned acc_width_p = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [width_p-1:0]       binary_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(width_p):0] count_o
`ifdef COUNTONES_STREAM_ACCUM_EN
    ,
    input  logic                     clear_i,
    output logic [acc_width_p-1:0]   accum_o
`endif
);

    localparam int unsigned chunks_lp = width_p / chunk_p;
    localparam int unsigned cnt_w_lp  = $clog2(width_p) + 1;
    localparam int unsigned ctr_w_lp  = $clog2(chunks_lp + 1);

    localparam logic [1:0] idle_st = 2'd0;
    localparam logic [1:0] busy_st = 2'd1;
    localparam logic [1:0] done_st = 2'd2;

    // Reject parameter sets that cannot be sliced into whole chunks
    if ((width_p % chunk_p) != 0) begin : g_bad_chunk
        $error("countones_stream: width_p must be an integer multiple of chunk_p");
    end
    if (acc_width_p == 0) begin : g_bad_acc
        $error("countones_stream: acc_width_p must be nonzero");
    end

    // Number of set bits in one chunk
    function automatic logic [cnt_w_lp-1:0] chunk_popcount(input logic [chunk_p-1:0] bits);
        logic [cnt_w_lp-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < chunk_p; i++) begin
            acc = acc + cnt_w_lp'(bits[i]);
        end
        return acc;
    endfunction

    logic [1:0]          state_q, state_n;
    logic [width_p-1:0]  shift_q, shift_n;
    logic [cnt_w_lp-1:0] sum_q, sum_n;
    logic [ctr_w_lp-1:0] ctr_q, ctr_n;
    logic [cnt_w_lp-1:0] count_n;
    logic                ready_n;
    logic                valid_n;
    logic [cnt_w_lp-1:0] chunk_pc_c;

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_n    = state_q;
        shift_n    = shift_q;
        sum_n      = sum_q;
        ctr_n      = ctr_q;
        count_n    = count_o;
        ready_n    = ready_o;
        valid_n    = valid_o;
        chunk_pc_c = chunk_popcount(shift_q[chunk_p-1:0]);

        case (state_q)
            idle_st: begin
                if (valid_i && ready_o) begin
                    shift_n = binary_i;
                    sum_n   = '0;
                    ctr_n   = ctr_w_lp'(chunks_lp);
                    state_n = busy_st;
                    ready_n = 1'b0;
                end
            end
            busy_st: begin
                sum_n   = sum_q + chunk_pc_c;
                shift_n = shift_q >> chunk_p;
                ctr_n   = ctr_q - ctr_w_lp'(1);
                // Last chunk: publish the total together with valid_o
                if (ctr_q == ctr_w_lp'(1)) begin
                    state_n = done_st;
                    valid_n = 1'b1;
                    count_n = sum_q + chunk_pc_c;
                end
            end
            done_st: begin
                if (ready_i) begin
                    state_n = idle_st;
                    valid_n = 1'b0;
                    ready_n = 1'b1;
                end
            end
            default: begin
                state_n = idle_st;
                valid_n = 1'b0;
                ready_n = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset dominates every other input
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= idle_st;
            shift_q <= '0;
            sum_q   <= '0;
            ctr_q   <= '0;
            count_o <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            sum_q   <= sum_n;
            ctr_q   <= ctr_n;
            count_o <= count_n;
            ready_o <= ready_n;
            valid_o <= valid_n;
        end
    end

`ifdef COUNTONES_STREAM_ACCUM_EN
    localparam int unsigned sat_w_lp =
        ((acc_width_p > cnt_w_lp) ? acc_width_p : cnt_w_lp) + 1;
    localparam logic [sat_w_lp-1:0] acc_max_lp = sat_w_lp'({acc_width_p{1'b1}});

    logic                handshake_c;
    logic [sat_w_lp-1:0] acc_base_c;
    logic [sat_w_lp-1:0] acc_sum_c;

    // Sum in a wider domain so the saturation compare sees the carry;
    // a clear coincident with a handshake restarts from zero
    always_comb begin
        handshake_c = valid_o && ready_i;
        acc_base_c  = clear_i ? '0 : sat_w_lp'(accum_o);
        acc_sum_c   = acc_base_c + sat_w_lp'(count_o);
    end

    // Saturating running total of delivered counts
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            accum_o <= '0;
        end else if (handshake_c) begin
            accum_o <= (acc_sum_c > acc_max_lp) ? acc_width_p'(acc_max_lp)
                                                : acc_width_p'(acc_sum_c);
        end else if (clear_i) begin
            accum_o <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_countones_stream.sv
// Directed bench for countones_stream: default 32/8 instance, a single-chunk
// 32/32 instance and an 8/2 instance swept over every input word.
`timescale 1ns/1ps
module tb_countones_stream;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    // 32-bit word, 8-bit chunks (accumulator, when built in, is 8 bits)
    logic        d_valid_i, d_ready_o, d_valid_o, d_ready_i;
    logic [31:0] d_binary_i;
    logic [5:0]  d_count_o;
    // 32-bit word, one 32-bit chunk
    logic        w_valid_i, w_ready_o, w_valid_o, w_ready_i;
    logic [31:0] w_binary_i;
    logic [5:0]  w_count_o;
    // 8-bit word, 2-bit chunks
    logic        s_valid_i, s_ready_o, s_valid_o, s_ready_i;
    logic [7:0]  s_binary_i;
    logic [3:0]  s_count_o;
`ifdef COUNTONES_STREAM_ACCUM_EN
    logic        d_clear_i;
    logic [7:0]  d_accum_o;
    logic [31:0] w_accum_o;
    logic [31:0] s_accum_o;
`endif

    countones_stream #(.width_p(32), .chunk_p(8), .acc_width_p(8)) u_d (
        .clk_i(clk), .reset_i(reset), .valid_i(d_valid_i), .ready_o(d_ready_o),
        .binary_i(d_binary_i), .valid_o(d_valid_o), .ready_i(d_ready_i), .count_o(d_count_o)
`ifdef COUNTONES_STREAM_ACCUM_EN
        , .clear_i(d_clear_i), .accum_o(d_accum_o)
`endif
    );

    countones_stream #(.width_p(32), .chunk_p(32), .acc_width_p(32)) u_w (
        .clk_i(clk), .reset_i(reset), .valid_i(w_valid_i), .ready_o(w_ready_o),
        .binary_i(w_binary_i), .valid_o(w_valid_o), .ready_i(w_ready_i), .count_o(w_count_o)
`ifdef COUNTONES_STREAM_ACCUM_EN
        , .clear_i(1'b0), .accum_o(w_accum_o)
`endif
    );

    countones_stream #(.width_p(8), .chunk_p(2), .acc_width_p(32)) u_s (
        .clk_i(clk), .reset_i(reset), .valid_i(s_valid_i), .ready_o(s_ready_o),
        .binary_i(s_binary_i), .valid_o(s_valid_o), .ready_i(s_ready_i), .count_o(s_count_o)
`ifdef COUNTONES_STREAM_ACCUM_EN
        , .clear_i(1'b0), .accum_o(s_accum_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic get_valid(input int sel);
        case (sel)
            0:       return d_valid_o;
            1:       return w_valid_o;
            default: return s_valid_o;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return d_ready_o;
            1:       return w_ready_o;
            default: return s_ready_o;
        endcase
    endfunction

    function automatic logic [63:0] get_count(input int sel);
        case (sel)
            0:       return 64'(d_count_o);
            1:       return 64'(w_count_o);
            default: return 64'(s_count_o);
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [31:0] w);
        case (sel)
            0:       begin d_valid_i = v; d_binary_i = w;      end
            1:       begin w_valid_i = v; w_binary_i = w;      end
            default: begin s_valid_i = v; s_binary_i = w[7:0]; end
        endcase
    endtask

    task automatic set_rdy(input int sel, input logic r);
        case (sel)
            0:       d_ready_i = r;
            1:       w_ready_i = r;
            default: s_ready_i = r;
        endcase
    endtask

    task automatic set_clr(input logic c);
`ifdef COUNTONES_STREAM_ACCUM_EN
        d_clear_i = c;
`else
        if (c) $display("note: clear requested without accumulator");
`endif
    endtask

    // Accept one word, measure edges to valid_o, check the count, then release
    task automatic run_word(input int sel, input logic [31:0] w, input int exp_edges,
                            input int exp_cnt, input string tag, input logic clr);
        int n;
        check({tag, "_rdy_pre"}, 64'(get_ready(sel)), 64'd1);
        drive(sel, 1'b1, w);
        @(posedge clk); #1;
        drive(sel, 1'b0, 32'h0);
        n = 0;
        while (!get_valid(sel) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_edges));
        check({tag, "_cnt"}, get_count(sel), 64'(exp_cnt));
        check({tag, "_rdy_done"}, 64'(get_ready(sel)), 64'd0);
        set_rdy(sel, 1'b1);
        set_clr(clr);
        @(posedge clk); #1;
        set_rdy(sel, 1'b0);
        set_clr(1'b0);
        check({tag, "_idle"}, 64'({get_valid(sel), get_ready(sel)}), 64'b01);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] sw;
        int         pc;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        drive(0, 1'b0, 32'h0); drive(1, 1'b0, 32'h0); drive(2, 1'b0, 32'h0);
        set_rdy(0, 1'b0); set_rdy(1, 1'b0); set_rdy(2, 1'b0);
        set_clr(1'b0);

        // Reset state, then holding idle
        do_reset();
        check("rst_ready", 64'(d_ready_o), 64'd1);
        check("rst_valid", 64'(d_valid_o), 64'd0);
        check("rst_count", 64'(d_count_o), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_idle", 64'({d_valid_o, d_ready_o, d_count_o}), 64'({1'b0, 1'b1, 6'd0}));

        // Main function, four edges per word at 32/8
        run_word(0, 32'hFFFF_FFFF, 4, 32, "ones", 1'b0);
        run_word(0, 32'h0000_0000, 4, 0,  "zeros", 1'b0);
        run_word(0, 32'h8000_0001, 4, 2,  "ends", 1'b0);
        run_word(0, 32'h1234_5678, 4, 13, "mixed", 1'b0);

        // ready_i while idle does nothing
        d_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        d_ready_i = 1'b0;
        check("rdy_idle", 64'({d_valid_o, d_ready_o, d_count_o}), 64'({1'b0, 1'b1, 6'd13}));

        // Stall in DONE with input noise, then release
        drive(0, 1'b1, 32'h0000_00FF);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1'b1, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000);
            @(posedge clk); #1;
            check("stall", 64'({d_valid_o, d_ready_o, d_count_o}), 64'({1'b1, 1'b0, 6'd8}));
        end
        drive(0, 1'b0, 32'h0);
        d_ready_i = 1'b1;
        @(posedge clk); #1;
        d_ready_i = 1'b0;
        check("stall_release", 64'({d_valid_o, d_ready_o}), 64'b01);
        check("count_hold", 64'(d_count_o), 64'd8);

        // Reset while BUSY abandons the word
        drive(0, 1'b1, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("busy_rst", 64'({d_valid_o, d_ready_o, d_count_o}), 64'({1'b0, 1'b1, 6'd0}));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("busy_rst_noval", 64'(d_valid_o), 64'd0);
        end

        // Single chunk: one edge to valid_o
        run_word(1, 32'h0F0F_0F0F, 1, 16, "wide", 1'b0);

        // Every 8-bit word through 2-bit chunks against a hand-rolled popcount
        for (int v = 0; v < 256; v++) begin
            sw = 8'(v);
            pc = 0;
            for (int b = 0; b < 8; b++) pc += int'(sw[b]);
            run_word(2, 32'(sw), 4, pc, "sweep", 1'b0);
        end

`ifdef COUNTONES_STREAM_ACCUM_EN
        // Saturating accumulator and clear behaviour
        do_reset();
        check("acc_rst", 64'(d_accum_o), 64'd0);
        for (int i = 0; i < 10; i++) begin
            run_word(0, 32'hFFFF_FFFF, 4, 32, "acc_word", 1'b0);
            if (i == 6) check("acc_224", 64'(d_accum_o), 64'd224);
        end
        check("acc_sat", 64'(d_accum_o), 64'd255);
        run_word(0, 32'h0000_001F, 4, 5, "acc_clr_hs", 1'b1);
        check("acc_clr_hs_val", 64'(d_accum_o), 64'd5);
        d_clear_i = 1'b1;
        @(posedge clk); #1;
        d_clear_i = 1'b0;
        check("acc_clr", 64'(d_accum_o), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/countones_stream.md
COUNTONES_STREAM -- requirements
Module: countones_stream

Interface
REQ-001 The block SHALL have parameter width_p, default 32, meaning input word width in bits.
REQ-002 The block SHALL have parameter chunk_p, default 8, meaning bits popcounted per cycle; width_p SHALL be an integer multiple of chunk_p (elaboration error otherwise).
REQ-003 The block SHALL have parameter acc_width_p, default 32, meaning accumulator width (used only under REQ-030).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Ports SHALL be:
- clk_i  in  1  sole clock, rising edge
- reset_i  in  1  synchronous active-high reset
- valid_i  in  1  input word valid
- ready_o  out  1  block can accept a word
- binary_i  in  width_p  word to count
- valid_o  out  1  result valid
- ready_i  in  1  consumer takes result
- count_o  out  $clog2(width_p)+1  number of 1 bits in accepted word
- clear_i  in  1  accumulator clear (present only under REQ-030)
- accum_o  out  acc_width_p  running total (present only under REQ-030)

Function
REQ-010 chunks_lp = width_p/chunk_p; states SHALL be IDLE, BUSY, DONE.
REQ-011 IDLE: ready_o=1, valid_o=0; on valid_i&ready_o SHALL capture binary_i into an internal shift register, clear the partial sum, load chunk counter with chunks_lp, go BUSY.
REQ-012 BUSY: ready_o=0, valid_o=0; each cycle SHALL add popcount of the low chunk_p bits of the shift register to the partial sum, shift right by chunk_p, decrement the counter; after the chunks_lp-th BUSY cycle SHALL go DONE.
REQ-013 valid_o SHALL rise exactly chunks_lp clock edges after the accepting edge (chunk_p==width_p: one edge).
REQ-014 DONE: ready_o=0, valid_o=1, count_o SHALL equal popcount of the captured word and stay stable until valid_o&ready_i; then go IDLE.
REQ-015 No same-cycle result-release/new-accept; maximum throughput SHALL be one word per chunks_lp+2 cycles.
REQ-016 Changes on binary_i/valid_i while BUSY or DONE SHALL be ignored.
REQ-017 count_o SHALL hold its last delivered value outside DONE; it is meaningful only when valid_o=1.
REQ-018 All-ones word SHALL yield count_o=width_p without overflow; all-zeros SHALL yield 0.
REQ-019 ready_i asserted while valid_o=0 SHALL have no effect.

Reset
REQ-020 reset_i SHALL have priority over all other inputs on the same edge.
REQ-021 After reset: state IDLE, ready_o=1, valid_o=0, count_o=0, partial sum 0, shift register 0, accum_o=0.
REQ-022 Reset in BUSY or DONE SHALL abandon the word; no result SHALL be emitted for it.

Configuration
REQ-030 Macro COUNTONES_STREAM_ACCUM_EN SHALL compile in clear_i and accum_o; without it neither port nor accumulator logic SHALL exist and behaviour is REQ-010..022 only.
REQ-031 With the macro, on each valid_o&ready_i edge accum_o SHALL add count_o, saturating at 2^acc_width_p-1.
REQ-032 With the macro, clear_i SHALL zero accum_o next edge; clear_i coincident with a handshake SHALL yield accum_o=count_o.

Verification (width_p=32, chunk_p=8 unless stated)
REQ-040 Reset, then hold: ready_o=1, valid_o=0, count_o=0; reset asserted in BUSY -> next edge ready_o=1, no valid_o.
REQ-041 Accept 32'hFFFF_FFFF -> valid_o exactly 4 edges later, count_o=32; accept 32'h0 -> count_o=0; accept 32'h8000_0001 -> 2.
REQ-042 Hold ready_i=0 for 5 cycles in DONE with binary_i toggling -> count_o and valid_o stable, ready_o=0; release -> IDLE next edge.
REQ-043 chunk_p=32: accept 32'h0F0F_0F0F -> valid_o 1 edge later, count_o=16; exhaustive sweep width_p=8, chunk_p=2 of all 256 words vs golden popcount.
REQ-044 With COUNTONES_STREAM_ACCUM_EN, acc_width_p=8: 10 words of 32'hFFFF_FFFF -> accum_o saturates at 255; clear_i with handshake of count 5 -> accum_o=5.
